// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the fetch PC, keeps a single request outstanding
// to instruction memory and holds the returned word for the IF/ID register.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        write_pc,
   input  logic        pc_redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr_out,
   output logic [31:0] pc_out,
   output logic        instr_valid,
   output logic        instr_stall
);

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic        kill_q, kill_d;
   logic [31:0] hold_instr_q, hold_instr_d;
   logic        instr_valid_q, instr_valid_d;
   logic [31:0] instr_out_q, instr_out_d;
   logic [31:0] pc_out_q, pc_out_d;
   logic [31:0] redirect_target_s;

   assign redirect_target_s = {redirect_pc[31:2], 2'b00};

   // Next-state: redirect outranks every other event in each state
   always_comb begin
      state_d      = state_q;
      fetch_pc_d   = fetch_pc_q;
      kill_d       = kill_q;
      hold_instr_d = hold_instr_q;
      case (state_q)
         S_REQ: begin
            if (pc_redirect) begin
               fetch_pc_d = redirect_target_s;
               if (imem_gnt) begin
                  // Old address was already accepted; its response must be dropped
                  state_d = S_WAIT;
                  kill_d  = 1'b1;
               end else begin
                  state_d = S_REQ;
               end
            end else if (imem_gnt) begin
               state_d = S_WAIT;
            end else begin
               state_d = S_REQ;
            end
         end
         S_WAIT: begin
            if (imem_rvalid) begin
               if (pc_redirect) begin
                  fetch_pc_d = redirect_target_s;
                  kill_d     = 1'b0;
                  state_d    = S_REQ;
               end else if (kill_q) begin
                  kill_d  = 1'b0;
                  state_d = S_REQ;
               end else begin
                  hold_instr_d = imem_rdata;
                  state_d      = S_HOLD;
               end
            end else if (pc_redirect) begin
               fetch_pc_d = redirect_target_s;
               kill_d     = 1'b1;
            end else begin
               state_d = S_WAIT;
            end
         end
         S_HOLD: begin
            if (pc_redirect) begin
               fetch_pc_d = redirect_target_s;
               state_d    = S_REQ;
            end else if (write_pc) begin
               fetch_pc_d = fetch_pc_q + 32'd4;
               state_d    = S_REQ;
            end else begin
               state_d = S_HOLD;
            end
         end
         default: begin
            state_d = S_REQ;
            kill_d  = 1'b0;
         end
      endcase
   end

   // Output images derived from next state so the outputs themselves are flops
   always_comb begin
      instr_valid_d = (state_d == S_HOLD);
      if (instr_valid_d) begin
         instr_out_d = hold_instr_d;
      end else begin
         instr_out_d = NOP_INSTR;
      end
      pc_out_d = fetch_pc_d;
   end

   // State and registered output update
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= S_REQ;
         fetch_pc_q    <= RESET_PC;
         kill_q        <= 1'b0;
         hold_instr_q  <= NOP_INSTR;
         instr_valid_q <= 1'b0;
         instr_out_q   <= NOP_INSTR;
         pc_out_q      <= RESET_PC;
      end else begin
         state_q       <= state_d;
         fetch_pc_q    <= fetch_pc_d;
         kill_q        <= kill_d;
         hold_instr_q  <= hold_instr_d;
         instr_valid_q <= instr_valid_d;
         instr_out_q   <= instr_out_d;
         pc_out_q      <= pc_out_d;
      end
   end

   assign imem_req    = (state_q == S_REQ) && !reset;
   assign imem_addr   = fetch_pc_q;
   assign instr_out   = instr_out_q;
   assign pc_out      = pc_out_q;
   assign instr_valid = instr_valid_q;
   assign instr_stall = !instr_valid_q;

endmodule
